// File: rtl/alb_seq.sv
// Registered, handshaked ALB with a persistent flag register for carry chaining.
// SHL and MUL iterate in BUSY, one bit per cycle; all other ops finish in one cycle.
module alb_seq #(
   parameter int W      = 10,
   parameter int MUL_EN = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         CI,
   input  logic         use_c,
   input  logic [2:0]   ALB_MI,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] F,
   output logic         CO,
   output logic         VO,
   output logic         NO,
   output logic         ZO,
   output logic [1:0]   dbg_state
);
   // Handshake: a request is taken on an edge with in_valid & in_ready;
   // a result is released on an edge with out_valid & out_ready.
   localparam int CW = $clog2(W + 1);
   localparam logic [W-1:0] W_V = W'(W);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t         state;
   logic [2:0]     op_r;
   logic [W-1:0]   work;
   logic [W-1:0]   mplier;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] mcand;
   logic [CW-1:0]  cnt;

   logic [W-1:0]   shamt, b_eff, sh_next, fin_res, fin_fv;
   logic [W:0]     sum;
   logic [2*W-1:0] mul_next;
   logic           cin, is_mul, go_busy, last, load, fin_co, fin_vo;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign dbg_state = state;

   assign shamt   = B % W_V;
   assign is_mul  = (ALB_MI == 3'b111) && (MUL_EN != 0);
   assign go_busy = ((ALB_MI == 3'b101) && (shamt != '0)) || is_mul;
   assign last    = (state == BUSY) && (cnt == CW'(1));
   assign load    = ((state == IDLE) && in_valid && !go_busy) || last;

   always_comb begin
      b_eff    = (ALB_MI == 3'b000) ? B : ~B;
      cin      = use_c ? CO : CI;
      sum      = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, cin};
      sh_next  = work << 1;
      mul_next = acc + (mplier[0] ? mcand : '0);
      fin_res  = '0;
      fin_fv   = '0;
      fin_co   = 1'b0;
      fin_vo   = 1'b0;
      if (state == BUSY) begin
         if (op_r == 3'b101) begin
            fin_res = sh_next;
            fin_fv  = sh_next;
            fin_co  = work[W-1];
         end else begin
            fin_res = mul_next[W-1:0];
            fin_fv  = mul_next[W-1:0];
            fin_co  = |mul_next[2*W-1:W];
         end
      end else begin
         case (ALB_MI)
            3'b000, 3'b001, 3'b010: begin
               // CMP reports flags of the difference but passes A through.
               fin_res = (ALB_MI == 3'b010) ? A : sum[W-1:0];
               fin_fv  = sum[W-1:0];
               fin_co  = sum[W];
               fin_vo  = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]);
            end
            3'b011:  begin fin_res = A | B; fin_fv = A | B; end
            3'b100:  begin fin_res = A & B; fin_fv = A & B; end
            3'b101:  begin fin_res = A;     fin_fv = A;     end
            default: begin fin_res = A ^ B; fin_fv = A ^ B; end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         op_r   <= '0;
         work   <= '0;
         mplier <= '0;
         acc    <= '0;
         mcand  <= '0;
         cnt    <= '0;
         F      <= '0;
         CO     <= 1'b0;
         VO     <= 1'b0;
         NO     <= 1'b0;
         ZO     <= 1'b0;
      end else begin
         if (load) begin
            F  <= fin_res;
            CO <= fin_co;
            VO <= fin_vo;
            NO <= fin_fv[W-1];
            ZO <= (fin_fv == '0);
         end
         case (state)
            IDLE: if (in_valid) begin
               op_r <= ALB_MI;
               if (is_mul) begin
                  acc    <= '0;
                  mcand  <= {{W{1'b0}}, A};
                  mplier <= B;
                  cnt    <= CW'(W);
                  state  <= BUSY;
               end else if (go_busy) begin
                  work  <= A;
                  cnt   <= CW'(shamt);
                  state <= BUSY;
               end else begin
                  state <= DONE;
               end
            end
            BUSY: begin
               work   <= sh_next;
               acc    <= mul_next;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               if (last) state <= DONE;
            end
            DONE: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alb_seq.sv
// Self-checking bench for alb_seq: scoreboard of expected {F,CO,VO,NO,ZO}.
module tb_alb_seq;
   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] A = '0;
   logic [W-1:0] B = '0;
   logic         CI = 1'b0;
   logic         use_c = 1'b0;
   logic [2:0]   ALB_MI = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] F;
   logic         CO, VO, NO, ZO;
   logic [1:0]   dbg_state;

   logic [W+3:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;
   logic         model_co = 1'b0;

   alb_seq #(.W(W), .MUL_EN(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .CI(CI), .use_c(use_c), .ALB_MI(ALB_MI),
      .out_valid(out_valid), .out_ready(out_ready), .F(F),
      .CO(CO), .VO(VO), .NO(NO), .ZO(ZO), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model built on integer arithmetic: returns {F, CO, VO, NO, ZO}.
   function automatic logic [W+3:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic cin);
      longint r, va, vb, sv;
      int s;
      logic [W-1:0] beff, f, nz;
      logic co, vo;
      co = 1'b0; vo = 1'b0; f = '0; nz = '0;
      case (op)
         3'd0, 3'd1, 3'd2: begin
            beff = (op == 3'd0) ? b : ~b;
            r  = longint'(a) + longint'(beff) + longint'(cin);
            co = (r >= (longint'(1) << W));
            nz = r[W-1:0];
            va = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
            vb = beff[W-1] ? longint'(beff) - (longint'(1) << W) : longint'(beff);
            sv = va + vb + longint'(cin);
            vo = (sv > (longint'(1) << (W-1)) - 1) || (sv < -(longint'(1) << (W-1)));
            f  = (op == 3'd2) ? a : nz;
         end
         3'd3: begin f = a | b; nz = f; end
         3'd4: begin f = a & b; nz = f; end
         3'd5: begin
            s  = int'(b) % W;
            r  = longint'(a) << s;
            f  = r[W-1:0]; nz = f;
            co = (s == 0) ? 1'b0 : a[W-s];
         end
         3'd6: begin f = a ^ b; nz = f; end
         default: begin
            r  = longint'(a) * longint'(b);
            f  = r[W-1:0]; nz = f;
            co = ((r >> W) != 0);
         end
      endcase
      return {f, co, vo, nz[W-1], (nz == '0)};
   endfunction

   function automatic int lat_of(input logic [2:0] op, input logic [W-1:0] b);
      if (op == 3'd7) return W + 1;
      if (op == 3'd5) return (int'(b) % W) + 1;
      return 1;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci, input logic uc, input int hold, input string name);
      int lat, exp_lat;
      logic [W+3:0] exp_v, got;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
      end
      in_valid = 1'b1; ALB_MI = op; A = a; B = b; CI = ci; use_c = uc;
      exp_q.push_back(model(op, a, b, uc ? model_co : ci));
      model_co = exp_q[$][3];
      exp_lat = lat_of(op, b);
      @(posedge clk); #1;
      in_valid = 1'b0; A = W'($urandom); B = W'($urandom); CI = 1'($urandom); use_c = 1'($urandom);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk); #1; lat++;
      end
      n_checks++;
      if (lat != exp_lat || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
      end
      exp_v = exp_q.pop_front();
      got = {F, CO, VO, NO, ZO};
      n_checks++;
      if (got !== exp_v) begin
         n_fail++;
         $display("FAIL %s result {F,CO,VO,NO,ZO}: got %h/%b want %h/%b", name,
                  got[W+3:4], got[3:0], exp_v[W+3:4], exp_v[3:0]);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1; ALB_MI = 3'($urandom); A = W'($urandom); B = W'($urandom);
         @(posedge clk); #1;
         n_checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || {F, CO, VO, NO, ZO} !== exp_v) begin
            n_fail++;
            $display("FAIL %s hold %0d: in_ready=%b out_valid=%b F=%h flags=%b want F=%h flags=%b",
                     name, i, in_ready, out_valid, F, {CO, VO, NO, ZO}, exp_v[W+3:4], exp_v[3:0]);
         end
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL %s release: in_ready=%b out_valid=%b want 1/0", name, in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({F, CO, VO, NO, ZO, out_valid, in_ready} !== {{W{1'b0}}, 6'b000001}) begin
         n_fail++; $display("FAIL reset state: F=%h flags=%b out_valid=%b in_ready=%b want 0/0000/0/1",
                            F, {CO, VO, NO, ZO}, out_valid, in_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_co = 1'b0;
   endtask

   task automatic test_add_sub();
      run_op(3'd0, 10'h3FF, 10'h001, 1'b0, 1'b0, 0, "add_wrap");
      run_op(3'd0, 10'h1FF, 10'h001, 1'b0, 1'b0, 0, "add_ovf");
      run_op(3'd1, 10'h005, 10'h007, 1'b1, 1'b0, 0, "sub_neg");
      run_op(3'd2, 10'h123, 10'h123, 1'b1, 1'b0, 0, "cmp_eq");
      run_op(3'd3, 10'h0F0, 10'h00F, 1'b0, 1'b0, 0, "or");
      run_op(3'd4, 10'h0F0, 10'h00F, 1'b0, 1'b0, 0, "and_zero");
      run_op(3'd6, 10'h2AA, 10'h155, 1'b0, 1'b0, 0, "xor");
   endtask

   task automatic test_carry_chain();
      run_op(3'd0, 10'h3FF, 10'h001, 1'b0, 1'b0, 0, "chain_lo");
      run_op(3'd0, 10'h000, 10'h000, 1'b0, 1'b1, 0, "chain_hi");
   endtask

   task automatic test_multicycle();
      run_op(3'd7, 10'd25, 10'd40, 1'b0, 1'b0, 0, "mul_1000");
      run_op(3'd7, 10'd32, 10'd32, 1'b0, 1'b0, 0, "mul_ovf");
      run_op(3'd5, 10'h201, 10'd1, 1'b0, 1'b0, 0, "shl_1");
      run_op(3'd5, 10'h3C5, 10'd13, 1'b0, 1'b0, 0, "shl_mod");
      run_op(3'd5, 10'h155, 10'd10, 1'b0, 1'b0, 0, "shl_0");
      run_op(3'd5, 10'h001, 10'd9, 1'b0, 1'b0, 0, "shl_max");
   endtask

   task automatic test_backpressure();
      run_op(3'd0, 10'h1FF, 10'h001, 1'b0, 1'b0, 3, "bp_add");
      run_op(3'd1, 10'h100, 10'h001, 1'b1, 1'b0, 0, "bp_next");
   endtask

   task automatic test_reset_mid();
      run_op(3'd0, 10'h3FF, 10'h3FF, 1'b0, 1'b0, 0, "pre_reset");
      @(negedge clk);
      in_valid = 1'b1; ALB_MI = 3'd7; A = 10'd25; B = 10'd40; CI = 1'b0; use_c = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({F, CO, VO, NO, ZO, out_valid} !== {{W{1'b0}}, 5'b00000}) begin
         n_fail++; $display("FAIL reset_mid: F=%h flags=%b out_valid=%b want 0/0000/0",
                            F, {CO, VO, NO, ZO}, out_valid);
      end
      model_co = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(3'd0, 10'h123, 10'h045, 1'b1, 1'b1, 0, "post_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 1), "random");
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard leftover: got %0d want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_carry_chain();
      test_multicycle();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
